// File: rtl/scv_romloader.sv
// scv_romloader: routes the host byte-download stream onto the SCV ROM-init bus and owns SYS_RESB.
// Optional CHKSUM output (16-bit sum of accepted bytes) is built when SCV_ROMLOADER_CHKSUM_EN is defined.
module scv_romloader #(
  parameter int HOLD_CYCLES = 1024,
  parameter int IDX_BOOT    = 0,
  parameter int IDX_CHR     = 1,
  parameter int IDX_CART    = 2
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        DL_ACTIVE,
  input  logic [7:0]  DL_INDEX,
  input  logic [7:0]  DL_DATA,
  input  logic        DL_WR,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic        SYS_RESB,
  output logic [17:0] CART_BYTES,
  output logic        OVERFLOW,
  output logic        BOOT_LOADED,
`ifdef SCV_ROMLOADER_CHKSUM_EN
  output logic [15:0] CHKSUM,
`endif
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0]  IDX_BOOT_B = 8'(IDX_BOOT);
  localparam logic [7:0]  IDX_CHR_B  = 8'(IDX_CHR);
  localparam logic [7:0]  IDX_CART_B = 8'(IDX_CART);
  localparam logic [17:0] LIM_BOOT   = 18'd4096;
  localparam logic [17:0] LIM_CHR    = 18'd1024;
  localparam logic [17:0] LIM_CART   = 18'd131072;
  localparam int          HW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t        r_state;
  logic [7:0]    r_index;
  logic [17:0]   r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_sel_boot;
  logic          r_sel_chr;
  logic          r_sel_cart;
  logic [24:0]   r_addr;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_sys_resb;
  logic [17:0]   r_cart_bytes;
  logic          r_ovf;
  logic          r_boot_loaded;

  logic          w_entry;
  logic          w_in_load;
  logic [7:0]    w_idx;
  logic [17:0]   w_cnt;
  logic          w_is_boot;
  logic          w_is_chr;
  logic          w_is_cart;
  logic          w_known;
  logic [17:0]   w_limit;
  logic          w_wr_ok;
  logic          w_accept;
  logic          w_over;
  logic [17:0]   w_cnt_next;

  // A DL_WR on the cycle DL_ACTIVE rises is byte 0 of the new download, so the
  // index and counter seen by the write path bypass the latched copies on entry.
  always_comb begin
    w_entry    = (r_state != ST_LOAD) && DL_ACTIVE;
    w_in_load  = (r_state == ST_LOAD) || w_entry;
    w_idx      = w_entry ? DL_INDEX : r_index;
    w_cnt      = w_entry ? 18'd0 : r_cnt;
    w_is_boot  = (w_idx == IDX_BOOT_B);
    w_is_chr   = (w_idx == IDX_CHR_B) && !w_is_boot;
    w_is_cart  = (w_idx == IDX_CART_B) && !w_is_boot && !w_is_chr;
    w_known    = w_is_boot || w_is_chr || w_is_cart;
    w_limit    = 18'd0;
    if (w_is_boot)      w_limit = LIM_BOOT;
    else if (w_is_chr)  w_limit = LIM_CHR;
    else if (w_is_cart) w_limit = LIM_CART;
    w_wr_ok    = w_in_load && DL_WR && w_known;
    w_accept   = w_wr_ok && (w_cnt < w_limit);
    w_over     = w_wr_ok && !(w_cnt < w_limit);
    w_cnt_next = w_cnt + 18'(w_accept);
  end

  // Strobe protocol: DL_WR is a one-cycle push with no back-pressure; each accepted
  // push yields exactly one ROMINIT_VALID beat on the following cycle, never stalled.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_state       <= ST_IDLE;
      r_index       <= 8'd0;
      r_cnt         <= 18'd0;
      r_hold        <= '0;
      r_sel_boot    <= 1'b0;
      r_sel_chr     <= 1'b0;
      r_sel_cart    <= 1'b0;
      r_addr        <= 25'd0;
      r_data        <= 8'd0;
      r_valid       <= 1'b0;
      r_sys_resb    <= 1'b0;
      r_cart_bytes  <= 18'd0;
      r_ovf         <= 1'b0;
      r_boot_loaded <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_addr <= 25'(w_cnt);
        r_data <= DL_DATA;
      end
      r_cnt <= w_cnt_next;
      if (w_entry) begin
        r_index <= DL_INDEX;
        r_ovf   <= 1'b0;
      end else if (w_over) begin
        r_ovf <= 1'b1;
      end
      // Next state is LOAD exactly when DL_ACTIVE is high, whatever the current state.
      r_sel_boot <= DL_ACTIVE && w_is_boot;
      r_sel_chr  <= DL_ACTIVE && w_is_chr;
      r_sel_cart <= DL_ACTIVE && w_is_cart;
      r_sys_resb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (DL_ACTIVE) r_state    <= ST_LOAD;
          else           r_sys_resb <= r_boot_loaded;
        end
        ST_LOAD: begin
          if (!DL_ACTIVE) begin
            r_state <= ST_HOLD;
            r_hold  <= '0;
            if (w_is_boot && (w_cnt_next != 18'd0)) r_boot_loaded <= 1'b1;
            if (w_is_cart) r_cart_bytes <= w_cnt_next;
          end
        end
        ST_HOLD: begin
          if (DL_ACTIVE) begin
            r_state <= ST_LOAD;
            r_hold  <= '0;
          end else if (r_hold == HOLD_LAST) begin
            r_state    <= ST_IDLE;
            r_sys_resb <= r_boot_loaded;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SCV_ROMLOADER_CHKSUM_EN
  logic [15:0] r_chksum;

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      r_chksum <= 16'd0;
    end else if (w_entry) begin
      r_chksum <= w_accept ? {8'd0, DL_DATA} : 16'd0;
    end else if (w_accept) begin
      r_chksum <= r_chksum + {8'd0, DL_DATA};
    end
  end

  assign CHKSUM = r_chksum;
`endif

  assign ROMINIT_SEL_BOOT = r_sel_boot;
  assign ROMINIT_SEL_CHR  = r_sel_chr;
  assign ROMINIT_SEL_CART = r_sel_cart;
  assign ROMINIT_ADDR     = r_addr;
  assign ROMINIT_DATA     = r_data;
  assign ROMINIT_VALID    = r_valid;
  assign SYS_RESB         = r_sys_resb;
  assign CART_BYTES       = r_cart_bytes;
  assign OVERFLOW         = r_ovf;
  assign BOOT_LOADED      = r_boot_loaded;
  assign o_dbg_state      = r_state;

  a_sel_onehot0: assert property (@(posedge CLK) disable iff (!RESB)
    $onehot0({r_sel_boot, r_sel_chr, r_sel_cart}));
  a_resb_idle: assert property (@(posedge CLK) disable iff (!RESB)
    r_sys_resb |-> (r_state == ST_IDLE));
  a_cnt_bound: assert property (@(posedge CLK) disable iff (!RESB)
    r_cnt <= LIM_CART);

endmodule

// File: tb/tb_scv_romloader.sv
// Randomized bench for scv_romloader: a download-level reference model predicts every
// ROM-init beat (cycle, select, address, data) and the status outputs after each download.
module tb_scv_romloader;
  localparam int H = 1024;

  logic        CLK = 1'b0;
  logic        RESB;
  logic        DL_ACTIVE;
  logic [7:0]  DL_INDEX;
  logic [7:0]  DL_DATA;
  logic        DL_WR;
  logic        ROMINIT_SEL_BOOT;
  logic        ROMINIT_SEL_CHR;
  logic        ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        SYS_RESB;
  logic [17:0] CART_BYTES;
  logic        OVERFLOW;
  logic        BOOT_LOADED;
  logic [1:0]  dbg_state;
`ifdef SCV_ROMLOADER_CHKSUM_EN
  logic [15:0] CHKSUM;
`endif

  scv_romloader #(.HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RESB(RESB), .DL_ACTIVE(DL_ACTIVE), .DL_INDEX(DL_INDEX),
    .DL_DATA(DL_DATA), .DL_WR(DL_WR),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_CART(ROMINIT_SEL_CART), .ROMINIT_ADDR(ROMINIT_ADDR),
    .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
    .SYS_RESB(SYS_RESB), .CART_BYTES(CART_BYTES), .OVERFLOW(OVERFLOW),
    .BOOT_LOADED(BOOT_LOADED),
`ifdef SCV_ROMLOADER_CHKSUM_EN
    .CHKSUM(CHKSUM),
`endif
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard entry: {due cycle[67:36], sel{boot,chr,cart}[35:33], addr[32:8], data[7:0]}
  logic [67:0] exp_q[$];

  // download-level model state
  bit          m_boot_loaded = 0;
  logic [17:0] m_cart_bytes  = 0;
  bit          m_ovf         = 0;
  logic [15:0] m_sum         = 0;

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2:0] sel_of(input logic [7:0] idx);
    case (idx)
      8'd0:    return 3'b100;
      8'd1:    return 3'b010;
      8'd2:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int limit_of(input logic [7:0] idx);
    case (idx)
      8'd0:    return 4096;
      8'd1:    return 1024;
      8'd2:    return 131072;
      default: return 0;
    endcase
  endfunction

  // monitor: every beat must match the head of the expected queue, cycle included
  always @(negedge CLK) begin
    logic [67:0] head;
    if (RESB) begin
      if (ROMINIT_VALID) begin
        if (exp_q.size() == 0) check_eq("spurious_valid", 72'd1, 72'd0);
        else begin
          head = exp_q.pop_front();
          check_eq("valid_beat",
                   {32'(cyc), ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
                    ROMINIT_ADDR, ROMINIT_DATA}, head);
        end
      end else if (exp_q.size() > 0) begin
        head = exp_q[0];
        if (head[67:36] < 32'(cyc)) begin
          check_eq("valid_missing", 72'd0, 72'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_values();
    check_eq("rst_valid", ROMINIT_VALID, 0);
    check_eq("rst_sel", {ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART}, 0);
    check_eq("rst_addr", ROMINIT_ADDR, 0);
    check_eq("rst_data", ROMINIT_DATA, 0);
    check_eq("rst_sys_resb", SYS_RESB, 0);
    check_eq("rst_cart_bytes", CART_BYTES, 0);
    check_eq("rst_overflow", OVERFLOW, 0);
    check_eq("rst_boot_loaded", BOOT_LOADED, 0);
`ifdef SCV_ROMLOADER_CHKSUM_EN
    check_eq("rst_chksum", CHKSUM, 0);
`endif
  endtask

  // driver: one download; random gaps between strobes; optional RESB pulse at byte abort_at
  task automatic download(input logic [7:0] idx, input int n, input int gap_max,
                          input bit wr_on_rise, input bit rand_data, input int abort_at);
    logic [2:0] esel;
    int lim;
    int k;
    esel  = sel_of(idx);
    lim   = limit_of(idx);
    m_sum = 0;
    m_ovf = 0;
    k     = 0;
    @(posedge CLK); #1;
    DL_ACTIVE = 1'b1;
    DL_INDEX  = idx;
    DL_WR     = 1'b0;
    if (wr_on_rise && n > 0) begin
      put_byte(k, esel, lim, rand_data);
      k++;
    end
    while (k < n) begin
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge CLK); #1;
        DL_WR = 1'b0;
      end
      @(posedge CLK); #1;
      put_byte(k, esel, lim, rand_data);
      if (k == abort_at) begin
        #1 RESB = 1'b0;
        #1 check_reset_values();
        exp_q.delete();
        DL_WR = 1'b0; DL_ACTIVE = 1'b0;
        m_boot_loaded = 0; m_cart_bytes = 0; m_ovf = 0; m_sum = 0;
        @(posedge CLK); #1 RESB = 1'b1;
        return;
      end
      k++;
      if (k == 2) begin
        @(negedge CLK);
        check_eq("mid_sel", {ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART}, esel);
        check_eq("mid_sys_resb", SYS_RESB, 0);
        check_eq("mid_overflow", OVERFLOW, 0);
      end
    end
    @(posedge CLK); #1;
    DL_WR = 1'b0;
    @(posedge CLK); #1;
    DL_ACTIVE = 1'b0;
    if (lim > 0 && n > lim) m_ovf = 1;
    if (idx == 8'd0 && n > 0) m_boot_loaded = 1;
    if (idx == 8'd2) m_cart_bytes = 18'((n < lim) ? n : lim);
  endtask

  task automatic put_byte(input int k, input logic [2:0] esel, input int lim, input bit rand_data);
    logic [7:0] d;
    d = rand_data ? 8'($urandom_range(255, 0)) : 8'(k);
    DL_WR   = 1'b1;
    DL_DATA = d;
    if (esel != 3'b000 && k < lim) begin
      exp_q.push_back({32'(cyc + 1), esel, 25'(k), d});
      m_sum = m_sum + {8'd0, d};
    end
  endtask

  // counts rising edges (sampled just after each) until SYS_RESB is seen high
  task automatic wait_release(input bit expect_rel, input int watch);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < watch) begin
      @(posedge CLK); #1;
      n++;
      if (SYS_RESB) seen = 1;
    end
    if (expect_rel) check_eq("release_edges", 72'(n), 72'(H + 1));
    else            check_eq("resb_stays_low", seen, 0);
  endtask

  task automatic post_checks();
    check_eq("boot_loaded", BOOT_LOADED, m_boot_loaded);
    check_eq("overflow", OVERFLOW, m_ovf);
    check_eq("cart_bytes", CART_BYTES, m_cart_bytes);
    check_eq("pending_beats", 72'(exp_q.size()), 0);
`ifdef SCV_ROMLOADER_CHKSUM_EN
    check_eq("chksum", CHKSUM, m_sum);
`endif
  endtask

  initial begin
    RESB = 1'b0; DL_ACTIVE = 1'b0; DL_INDEX = 8'd0; DL_DATA = 8'd0; DL_WR = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_reset_values();
    RESB = 1'b1;

    // idle after reset: no release, no beats
    wait_release(0, 10000);
    check_eq("idle_boot_loaded", BOOT_LOADED, 0);

    // CHR before any boot: SYS_RESB must stay low past the hold
    download(8'd1, 50, 1, 0, 1, -1);
    wait_release(0, H + 50);
    post_checks();

    // full boot ROM, contiguous, data = addr[7:0]
    download(8'd0, 4096, 0, 0, 0, -1);
    wait_release(1, H + 20);
    post_checks();

    // CHR overflow: 1030 writes, 1024 beats
    download(8'd1, 1030, 0, 0, 1, -1);
    wait_release(1, H + 20);
    post_checks();

    // cart with random gaps, clears previous OVERFLOW
    download(8'd2, 8192, 2, 0, 1, -1);
    wait_release(1, H + 20);
    post_checks();

    // unknown index: no beats, no selects
    download(8'd7, 100, 1, 1, 1, -1);
    wait_release(1, H + 20);
    post_checks();

    // RESB pulse at cart byte 500
    download(8'd2, 2000, 1, 0, 1, 500);
    check_eq("after_abort_boot", BOOT_LOADED, 0);

    // zero-byte boot does not count as a load
    download(8'd0, 0, 0, 0, 1, -1);
    wait_release(0, H + 50);
    post_checks();

    // boot with DL_WR on the rising cycle of DL_ACTIVE
    download(8'd0, 20, 1, 1, 1, -1);
    wait_release(0, 100);
    // re-entry from HOLD keeps SYS_RESB low and restarts the hold
    download(8'd2, 300, 1, 1, 1, -1);
    wait_release(1, H + 20);
    post_checks();

    repeat (3) @(posedge CLK);
    check_eq("final_queue_empty", 72'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/scv_romloader.md
Name: scv_romloader

Overview:
Upstream feeder for the SCV core's ROM-init bus. Takes the host byte-download stream (index-tagged, one byte per write strobe) and routes it onto the core's ROMINIT_SEL_BOOT/CHR/CART, ROMINIT_ADDR, ROMINIT_DATA and ROMINIT_VALID inputs. It owns the system reset, SYS_RESB. SYS_RESB is held low until a boot ROM has been loaded, during every download, and for a fixed delay afterwards.

Parameters:
HOLD_CYCLES, 1024, CLK cycles SYS_RESB stays low after a download ends
IDX_BOOT, 0, download index routed to boot ROM (limit 4096 bytes)
IDX_CHR, 1, download index routed to character ROM (limit 1024 bytes)
IDX_CART, 2, download index routed to cartridge (limit 131072 bytes)

Ports:
CLK  in  1  core clock, same as SCV core CLK
RESB  in  1  asynchronous active-low reset
DL_ACTIVE  in  1  host download in progress (level)
DL_INDEX  in  8  download file index, stable while DL_ACTIVE=1
DL_DATA  in  8  download byte, valid when DL_WR=1
DL_WR  in  1  one-cycle byte strobe; may assert every cycle
ROMINIT_SEL_BOOT  out  1  region select to core
ROMINIT_SEL_CHR  out  1  region select to core
ROMINIT_SEL_CART  out  1  region select to core
ROMINIT_ADDR  out  25  byte address within selected region
ROMINIT_DATA  out  8  byte to write
ROMINIT_VALID  out  1  one-cycle write strobe
SYS_RESB  out  1  active-low reset to SCV core
CART_BYTES  out  18  byte count of last completed cart download (0..131072)
OVERFLOW  out  1  sticky: current/last download exceeded region limit
BOOT_LOADED  out  1  boot ROM loaded at least once since RESB

Behaviour:
- Reset (RESB=0, async): state IDLE; all ROMINIT_* = 0; SYS_RESB=0; CART_BYTES=0; OVERFLOW=0; BOOT_LOADED=0; byte counter=0; hold counter=0.
- Clock/reset: one clock, CLK. RESB is asynchronous, active-low. All outputs are registered.
- States:
  - IDLE: DL_ACTIVE=1 -> LOAD. SYS_RESB=BOOT_LOADED.
  - LOAD: SYS_RESB=0. On entry, byte counter and OVERFLOW clear and DL_INDEX is latched. DL_ACTIVE=0 -> HOLD.
  - HOLD: SYS_RESB=0; hold counter counts 0..HOLD_CYCLES-1. On reaching HOLD_CYCLES-1 -> IDLE. DL_ACTIVE=1 during HOLD -> LOAD; hold counter clears.
- SEL outputs: registered from the latched index while in LOAD; all 0 in other states. Unknown index: all SEL=0.
- Write path:
  - DL_WR=1 in LOAD with a known index and counter < limit -> next cycle ROMINIT_VALID=1 (1 cycle), ROMINIT_ADDR=counter zero-extended, ROMINIT_DATA=DL_DATA. Latency is exactly 1 cycle.
  - Counter increments by 1 per accepted DL_WR.
  - Back-to-back DL_WR gives back-to-back VALID with consecutive addresses.
- DL_WR in the same cycle as the DL_ACTIVE rise: taken as byte 0 (address 0); the index is taken from the same cycle.
- Limit reached: further DL_WR are dropped (no VALID, counter saturates) and OVERFLOW is set. OVERFLOW stays set until the next LOAD entry.
- Unknown index: all DL_WR are dropped; OVERFLOW unaffected.
- DL_WR outside LOAD: ignored.
- LOAD->HOLD exit:
  - Boot index with counter >= 1 sets BOOT_LOADED.
  - Cart index: CART_BYTES = final counter.
  - A zero-byte boot download does not set BOOT_LOADED.
- SYS_RESB rises only on the HOLD->IDLE transition with BOOT_LOADED=1. Without a boot load it stays 0 indefinitely.
- RESB asserted mid-LOAD or mid-HOLD: immediate async clear to reset values; any in-flight VALID is dropped.

Optional Feature:
SCV_ROMLOADER_CHKSUM_EN.
- Defined: adds output port CHKSUM (16 bits). It is a modulo-2^16 sum of all accepted bytes of the current download. It clears on LOAD entry and updates in the same cycle VALID is asserted; dropped bytes are excluded. It holds its value after the download ends. RESB clears it to 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release with no download -> SYS_RESB=0, BOOT_LOADED=0, no VALID for 10000 cycles.
- Boot download: index 0, 4096 bytes on consecutive cycles, data=addr[7:0] -> 4096 VALID pulses with SEL_BOOT=1 and ADDR 0..4095, 1 cycle after each DL_WR. Then SYS_RESB stays 0 for exactly HOLD_CYCLES after DL_ACTIVE falls and rises to 1; BOOT_LOADED=1; OVERFLOW=0.
- CHR overflow: index 1, 1030 bytes -> 1024 VALID pulses (ADDR 0..1023), OVERFLOW=1; next download clears OVERFLOW.
- Cart: index 2, 8192 bytes with random gaps between DL_WR -> SEL_CART=1, CART_BYTES=8192, SYS_RESB low throughout and re-released after HOLD_CYCLES. With CHKSUM_EN, CHKSUM = software sum mod 65536.
- Index 7, 100 bytes -> no VALID, all SEL=0, SYS_RESB low during download and HOLD, then returns high.
- RESB pulsed mid cart download at byte 500 -> all outputs at reset values within the same cycle, BOOT_LOADED=0. A new download with DL_WR on the rising cycle of DL_ACTIVE writes address 0.
